// File: rtl/wr_ptr_burst.sv
// Write-side pointer controller for the AXI-Stream FIFO.
// Accepts 1..MAX_INCR entries per cycle; rejects writes that do not fit.
module wr_ptr_burst #(
    parameter int ALEN      = 8,
    parameter int MAX_INCR  = 4,
    parameter int AF_THRESH = 4,
    parameter int CLEN      = $clog2(MAX_INCR + 1)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_wen,
    input  logic [CLEN-1:0] i_wlen,
    input  logic [ALEN:0]   i_rptr,
    input  logic            i_ovf_clr,
    output logic [ALEN-1:0] o_waddr,
    output logic            o_ram_wen,
    output logic [ALEN:0]   o_wptr,
    output logic [ALEN:0]   o_wptr_gray,
    output logic [ALEN:0]   o_wfree,
    output logic            o_wfull,
    output logic            o_wafull,
    output logic            o_woverflow,
    output logic            o_woverflow_sticky
);

    localparam int PW = ALEN + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(2 ** ALEN);
    localparam logic [PW-1:0] AF_P    = PW'(AF_THRESH);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] gray_q, gray_d;
    logic [PW-1:0] free_q, free_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;
    logic          sticky_q, sticky_d;

    logic [PW-1:0] wlen_x;
    logic [PW-1:0] used_c;
    logic [PW-1:0] free_c;
    logic [PW-1:0] used_n;
    logic          req_c;
    logic          fit_c;
    logic          accept_c;
    logic          reject_c;

    // Current free space; a read pointer claiming more than DEPTH used
    // is treated as a completely full FIFO.
    always_comb begin
        wlen_x   = PW'(i_wlen);
        used_c   = wptr_q - i_rptr;
        free_c   = (used_c > DEPTH_P) ? '0 : DEPTH_P - used_c;
        req_c    = i_wen & (i_wlen != '0);
        fit_c    = (wlen_x <= free_c);
        accept_c = req_c & fit_c;
        reject_c = req_c & ~fit_c;
    end

    // Next pointer and status derived from it and the present read pointer.
    always_comb begin
        wptr_d   = accept_c ? (wptr_q + wlen_x) : wptr_q;
        gray_d   = wptr_d ^ (wptr_d >> 1);
        used_n   = wptr_d - i_rptr;
        free_d   = (used_n > DEPTH_P) ? '0 : DEPTH_P - used_n;
        full_d   = (free_d == '0);
        afull_d  = (free_d <= AF_P);
        ovf_d    = reject_c;
        sticky_d = reject_c | (sticky_q & ~i_ovf_clr);
    end

    // State and registered status.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q   <= '0;
            gray_q   <= '0;
            free_q   <= DEPTH_P;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            gray_q   <= gray_d;
            free_q   <= free_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
        end
    end

    assign o_waddr            = wptr_q[ALEN-1:0];
    assign o_ram_wen          = accept_c;
    assign o_wptr             = wptr_q;
    assign o_wptr_gray        = gray_q;
    assign o_wfree            = free_q;
    assign o_wfull            = full_q;
    assign o_wafull           = afull_q;
    assign o_woverflow        = ovf_q;
    assign o_woverflow_sticky = sticky_q;

endmodule

// File: doc/wr_ptr_burst.md
Name: wr_ptr_burst

Overview:
Write-side pointer controller for the AXI-Stream FIFO. It is the parametrised successor to the single-increment write pointer. It accepts writes of 1..MAX_INCR entries per cycle and rejects any write that does not fit. It provides registered full, almost-full and free-count status, a sticky overflow flag, and a Gray-coded pointer copy for a later dual-clock read side.

Parameters:
ALEN, 8, address width; DEPTH = 2**ALEN entries
MAX_INCR, 4, largest entry count per write; legal range 1..DEPTH
AF_THRESH, 4, o_wafull asserts when free count <= AF_THRESH; legal range 0..DEPTH-1
CLEN, $clog2(MAX_INCR+1), width of i_wlen (derived, do not override)

Ports:
clk  input  1  clock; all state on rising edge
rstn  input  1  asynchronous active-low reset
i_wen  input  1  write request
i_wlen  input  CLEN  entries in this write; 0 = no-op
i_rptr  input  ALEN+1  binary read pointer (same clock domain)
i_ovf_clr  input  1  clears o_woverflow_sticky
o_waddr  output  ALEN  RAM base address for the write, = wptr[ALEN-1:0]
o_ram_wen  output  1  write accepted this cycle (combinational)
o_wptr  output  ALEN+1  registered binary write pointer
o_wptr_gray  output  ALEN+1  registered Gray code of o_wptr
o_wfree  output  ALEN+1  registered free-entry count, 0..DEPTH
o_wfull  output  1  registered, free == 0
o_wafull  output  1  registered, free <= AF_THRESH
o_woverflow  output  1  one-cycle pulse when a write is rejected
o_woverflow_sticky  output  1  latched overflow indicator

Behaviour:
- Reset (async assert, sync release): wptr=0, o_wptr_gray=0, o_wfree=DEPTH, o_wfull=0, o_wafull=0, o_woverflow=0, o_woverflow_sticky=0.
- Arithmetic is modulo 2**(ALEN+1).
  - used = wptr - i_rptr.
  - free = DEPTH - used.
  - The MSB distinguishes full from empty when the low bits are equal.
  - The pointer wraps silently from 2**(ALEN+1)-1 to 0.
- accept = i_wen & (i_wlen != 0) & (i_wlen <= free), where free is computed combinationally from the current wptr and i_rptr.
  - o_ram_wen = accept, in the same cycle.
  - o_waddr = wptr[ALEN-1:0].
  - The RAM writes entries o_waddr .. o_waddr+i_wlen-1, wrapping mod DEPTH.
- On accept: wptr <= wptr + i_wlen on the next edge. o_wptr_gray <= gray(wptr + i_wlen) on the same edge.
- Reject (i_wen & i_wlen != 0 & i_wlen > free):
  - wptr holds and o_ram_wen = 0.
  - Next cycle: o_woverflow = 1 for exactly one cycle, and o_woverflow_sticky = 1.
  - A partial write is never performed.
- i_wen with i_wlen = 0: no pointer change, no overflow.
- i_wlen > MAX_INCR is illegal input. The bench flags it with an assertion; RTL behaviour is then unspecified.
- Status registers update every cycle from the next wptr and the current i_rptr:
  - o_wfree <= DEPTH - (wptr_next - i_rptr).
  - o_wfull <= (o_wfree_next == 0).
  - o_wafull <= (o_wfree_next <= AF_THRESH).
  - Consequence: status is exact for this block's own writes and lags a reader's i_rptr advance by one cycle (conservative; never under-reports fullness).
- Acceptance itself uses the combinational free, so a write in the cycle after a read release succeeds even if o_wfull is still 1.
- If i_rptr implies used > DEPTH, the input is illegal. The block treats free as 0: all writes are rejected and o_wfull = 1.
- o_woverflow_sticky clears on i_ovf_clr. If i_ovf_clr and a new reject coincide, set wins (sticky stays 1).
- o_wptr_gray changes in at most one bit per single-entry increment. Multi-entry increments may change several bits; this is acceptable only while the consumer is same-clock.

Test Plan:
ALEN=4 (DEPTH=16), MAX_INCR=4, AF_THRESH=2 for all cases.
1. Reset, i_rptr=0, 16 single writes (i_wlen=1) -> o_waddr 0x0..0xF in order, o_wptr=0x10, o_wfull=1, o_wfree=0, o_wafull set from the cycle after the 14th write (o_wfree=2).
2. From full, one more write i_wlen=1 -> o_ram_wen=0, o_wptr stays 0x10, o_woverflow pulses 1 cycle, sticky=1. Then pulse i_ovf_clr -> sticky=0.
3. i_rptr=0x0E, wptr=0x1D (free=1), write i_wlen=2 -> rejected, overflow pulse. Then i_rptr=0x0F, same cycle write i_wlen=2 -> accepted, wptr=0x1F.
4. Wrap: i_rptr=0x1C, wptr=0x1E, write i_wlen=4 -> o_waddr=0xE, wptr=0x02, o_wfree=10, o_wptr_gray=0x03.
5. Async reset asserted mid-stream (wptr=0x07, sticky=1) between clock edges -> all outputs return to reset values immediately. The first write after release gets o_waddr=0x0.
6. i_ovf_clr asserted in the same cycle as a reject -> sticky remains 1. i_wen=1 with i_wlen=0 -> no pointer change, no overflow pulse.
